// File: rtl/microsequencer_if.sv
// Control-store sequencing bus between the control unit and the microsequencer.
interface microsequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [2:0]        n_sel;
    logic [ADDR_W-1:0] enc_addr;
    logic [ADDR_W-1:0] cr_addr;
    logic              cond;
    logic              inv;
    logic              moc;
    logic [ADDR_W-1:0] state;
    logic              moc_wait;
    logic              bus_err;

    // Control unit side: supplies select code and address sources.
    modport master (
        output n_sel, enc_addr, cr_addr, cond, inv, moc,
        input  state, moc_wait, bus_err
    );

    // Sequencer side: consumes selects, returns the current address.
    modport slave (
        input  n_sel, enc_addr, cr_addr, cond, inv, moc,
        output state, moc_wait, bus_err
    );
endinterface

// File: rtl/microsequencer.sv
// Next-address engine for the microprogrammed control unit.
module microsequencer #(
    parameter int unsigned       ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter logic [ADDR_W-1:0] ABORT_ADDR  = ADDR_W'(8'hFF),
    parameter int unsigned       MOC_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    microsequencer_if.slave bus
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        SEL_ENCODE   = 3'd0,
        SEL_FETCH    = 3'd1,
        SEL_INC      = 3'd2,
        SEL_CBR      = 3'd3,
        SEL_WAIT_MOC = 3'd4,
        SEL_JUMP     = 3'd5,
        SEL_CALL     = 3'd6,
        SEL_RET      = 3'd7
    } nsel_e;

    logic [ADDR_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0] ret_q, ret_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              moc_wait_q, moc_wait_d;
    logic              bus_err_q, bus_err_d;
    logic [ADDR_W-1:0] inc;
    logic              ec;
    nsel_e             sel;

    // Next-address selection, MOC wait counting and return-register update.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        wait_cnt_d = '0;
        moc_wait_d = 1'b0;
        bus_err_d  = 1'b0;
        inc        = state_q + ADDR_W'(1);
        ec         = bus.cond ^ bus.inv;
        sel        = nsel_e'(bus.n_sel);

        unique case (sel)
            SEL_ENCODE: state_d = bus.enc_addr;
            SEL_FETCH:  state_d = RESET_ADDR + ADDR_W'(1);
            SEL_INC:    state_d = inc;
            SEL_CBR:    state_d = ec ? bus.cr_addr : inc;
            SEL_WAIT_MOC: begin
                if (bus.moc) begin
                    state_d = inc;
                end else if (wait_cnt_q == CNT_W'(MOC_TIMEOUT - 1)) begin
                    state_d   = ABORT_ADDR;
                    bus_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    moc_wait_d = 1'b1;
                end
            end
            SEL_JUMP:   state_d = bus.cr_addr;
            SEL_CALL: begin
                ret_d   = inc;
                state_d = bus.cr_addr;
            end
            SEL_RET:    state_d = ret_q;
        endcase
    end

    // State, return register and output registers; reset abandons any wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RESET_ADDR;
            ret_q      <= '0;
            wait_cnt_q <= '0;
            moc_wait_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            wait_cnt_q <= wait_cnt_d;
            moc_wait_q <= moc_wait_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.moc_wait = moc_wait_q;
    assign bus.bus_err  = bus_err_q;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for the microsequencer: vector table, corner sequences, random vs model.
module tb_microsequencer;

    localparam int TIMEOUT = 15;

    logic clk;
    logic reset;

    microsequencer_if #(.ADDR_W(8)) bus ();

    microsequencer #(
        .ADDR_W(8),
        .RESET_ADDR(8'h00),
        .ABORT_ADDR(8'hFF),
        .MOC_TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] n_sel;
        logic [7:0] enc;
        logic [7:0] cr;
        logic       cond;
        logic       inv;
        logic       moc;
        logic [7:0] exp_state;
        logic       exp_wait;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    // Reference model: plain arithmetic over the sequencing rules.
    int m_state, m_ret, m_waited, m_wait, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int es, input int ew, input int ee);
        check({tag, ".state"},    32'(bus.state),    32'(es));
        check({tag, ".moc_wait"}, 32'(bus.moc_wait), 32'(ew));
        check({tag, ".bus_err"},  32'(bus.bus_err),  32'(ee));
    endtask

    task automatic drive(input logic rst, input logic [2:0] sel, input logic [7:0] enc,
                         input logic [7:0] cr, input logic c, input logic i, input logic m);
        reset        = rst;
        bus.n_sel    = sel;
        bus.enc_addr = enc;
        bus.cr_addr  = cr;
        bus.cond     = c;
        bus.inv      = i;
        bus.moc      = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [7:0] a);
        drive(1'b0, 3'd5, 8'h00, a, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("jump", a, 0, 0);
    endtask

    task automatic add(input logic [2:0] s, input logic [7:0] e, input logic [7:0] cr,
                       input logic c, input logic i, input logic m,
                       input logic [7:0] es, input logic ew, input logic ee);
        vec_t v;
        v.n_sel = s; v.enc = e; v.cr = cr; v.cond = c; v.inv = i; v.moc = m;
        v.exp_state = es; v.exp_wait = ew; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic model_step(input logic rst, input int sel, input int enc, input int cr,
                              input int c, input int i, input int m);
        int nxt;
        nxt   = (m_state + 1) % 256;
        m_err = 0;
        if (rst) begin
            m_state = 0; m_ret = 0; m_waited = 0; m_wait = 0;
        end else if (sel == 4) begin
            if (m != 0) begin
                m_state = nxt; m_waited = 0; m_wait = 0;
            end else if (m_waited + 1 >= TIMEOUT) begin
                m_state = 255; m_err = 1; m_waited = 0; m_wait = 0;
            end else begin
                m_waited = m_waited + 1; m_wait = 1;
            end
        end else begin
            m_waited = 0;
            m_wait   = 0;
            case (sel)
                0: m_state = enc;
                1: m_state = 1;
                2: m_state = nxt;
                3: m_state = ((c ^ i) != 0) ? cr : nxt;
                5: m_state = cr;
                6: begin m_ret = nxt; m_state = cr; end
                default: m_state = m_ret;
            endcase
        end
    endtask

    initial begin
        // Reset with a JUMP pending: reset wins.
        drive(1'b1, 3'd5, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0);
        tick();
        check_all("reset", 8'h00, 0, 0);
        tick();
        check_all("reset_hold", 8'h00, 0, 0);
        drive(1'b0, 3'd2, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_all("release_inc", k, 0, 0);
        end

        // Single-cycle decode vectors.
        add(3'd5, 8'h00, 8'h10, 0, 0, 0, 8'h10, 0, 0);
        add(3'd3, 8'h00, 8'h30, 1, 0, 0, 8'h30, 0, 0);
        add(3'd5, 8'h00, 8'h10, 0, 0, 0, 8'h10, 0, 0);
        add(3'd3, 8'h00, 8'h30, 1, 1, 0, 8'h11, 0, 0);
        add(3'd5, 8'h00, 8'h10, 0, 0, 0, 8'h10, 0, 0);
        add(3'd3, 8'h00, 8'h30, 0, 1, 0, 8'h30, 0, 0);
        add(3'd3, 8'h00, 8'h50, 0, 0, 0, 8'h31, 0, 0);
        add(3'd5, 8'h00, 8'h20, 0, 0, 0, 8'h20, 0, 0);
        add(3'd6, 8'h00, 8'h80, 0, 0, 0, 8'h80, 0, 0);
        add(3'd2, 8'h00, 8'h00, 0, 0, 0, 8'h81, 0, 0);
        add(3'd2, 8'h00, 8'h00, 0, 0, 0, 8'h82, 0, 0);
        add(3'd7, 8'h00, 8'h00, 0, 0, 0, 8'h21, 0, 0);
        add(3'd5, 8'h00, 8'hFF, 0, 0, 0, 8'hFF, 0, 0);
        add(3'd2, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        add(3'd1, 8'h00, 8'h77, 0, 0, 0, 8'h01, 0, 0);
        add(3'd0, 8'h5A, 8'h77, 0, 0, 0, 8'h5A, 0, 0);
        add(3'd7, 8'h00, 8'h00, 0, 0, 0, 8'h21, 0, 0);
        add(3'd6, 8'h00, 8'hC0, 0, 0, 0, 8'hC0, 0, 0);
        add(3'd6, 8'h00, 8'h40, 0, 0, 0, 8'h40, 0, 0);
        add(3'd7, 8'h00, 8'h00, 0, 0, 0, 8'hC1, 0, 0);
        add(3'd4, 8'h00, 8'h00, 0, 0, 1, 8'hC2, 0, 0);
        foreach (vecs[k]) begin
            drive(1'b0, vecs[k].n_sel, vecs[k].enc, vecs[k].cr,
                  vecs[k].cond, vecs[k].inv, vecs[k].moc);
            tick();
            check_all($sformatf("vec%0d", k), vecs[k].exp_state, vecs[k].exp_wait, vecs[k].exp_err);
        end

        // MOC handshake: three wait cycles then completion.
        jump_to(8'h05);
        drive(1'b0, 3'd4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_all("moc_hold", 8'h05, 1, 0);
        end
        bus.moc = 1'b1;
        tick();
        check_all("moc_done", 8'h06, 0, 0);

        // Timeout: 14 holds, abort on the 15th edge, one-cycle bus_err.
        jump_to(8'h10);
        drive(1'b0, 3'd4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            check_all("to_hold", 8'h10, 1, 0);
        end
        tick();
        check_all("to_abort", 8'hFF, 0, 1);
        bus.n_sel = 3'd2;
        tick();
        check_all("to_after", 8'h00, 0, 0);

        // MOC arriving on the timeout cycle wins.
        jump_to(8'h10);
        drive(1'b0, 3'd4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            check_all("late_hold", 8'h10, 1, 0);
        end
        bus.moc = 1'b1;
        tick();
        check_all("late_moc", 8'h11, 0, 0);

        // Reset mid-wait, then a fresh wait needs the full count.
        jump_to(8'h10);
        drive(1'b0, 3'd4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_all("rw_hold", 8'h10, 1, 0);
        end
        reset = 1'b1;
        tick();
        check_all("rw_reset", 8'h00, 0, 0);
        reset = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            check_all("rw_rehold", 8'h00, 1, 0);
        end
        tick();
        check_all("rw_abort", 8'hFF, 0, 1);

        // Random stimulus against the reference model.
        drive(1'b1, 3'd2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        model_step(1'b1, 2, 0, 0, 0, 0, 0);
        tick();
        check_all("rnd_reset", m_state, m_wait, m_err);
        for (int k = 0; k < 1500; k++) begin
            logic       r;
            logic [2:0] s;
            logic [7:0] e, cr;
            logic       c, i, m;
            r  = ($urandom_range(0, 79) == 0);
            s  = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            e  = 8'($urandom);
            cr = 8'($urandom);
            c  = 1'($urandom);
            i  = 1'($urandom);
            m  = ($urandom_range(0, 9) == 0);
            drive(r, s, e, cr, c, i, m);
            model_step(r, int'(s), int'(e), int'(cr), int'(c), int'(i), int'(m));
            tick();
            check_all($sformatf("rnd%0d", k), m_state, m_wait, m_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Next-state engine of the microprogrammed control unit.
- Holds the current control-store address. Each cycle it computes the next address from the 3-bit next-address select code (produced by the N-select mux from constant 1, instruction bits, or the microinstruction T field), the instruction encoder, the microinstruction CR field, the condition tester and memory-operation-complete (MOC).
- Its state output indexes the control ROM that drives the datapath mux selects (MA..MJ).

Parameters:
- ADDR_W, 8, control-store address width.
- RESET_ADDR, 0, address loaded on reset.
- ABORT_ADDR, 8'hFF, address entered on MOC timeout.
- MOC_TIMEOUT, 15, max consecutive wait cycles before abort (1..255).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- n_sel  in  3  next-address select code.
- enc_addr  in  ADDR_W  start address from the instruction encoder.
- cr_addr  in  ADDR_W  branch/target field of the current microinstruction.
- cond  in  1  condition tester result.
- inv  in  1  microinstruction invert bit; effective condition ec = cond ^ inv.
- moc  in  1  memory operation complete.
- state  out  ADDR_W  current control-store address.
- moc_wait  out  1  high while the sequencer is held waiting for MOC.
- bus_err  out  1  one-cycle pulse on MOC timeout.

Behaviour:
- Reset:
  - Sampled at the clock edge and overrides everything.
  - state=RESET_ADDR, ret_reg=0, wait_cnt=0, moc_wait=0, bus_err=0.
  - Reset during a wait abandons the wait with no bus_err.
- All outputs are registered. The next state is visible one cycle after the n_sel/inputs are sampled.
- Incrementer: inc = state+1, modulo 2^ADDR_W (0xFF wraps to 0x00).
- n_sel decode:
  - 0 ENCODE: state <= enc_addr.
  - 1 FETCH: state <= RESET_ADDR+1.
  - 2 INC: state <= inc.
  - 3 CBR: state <= ec ? cr_addr : inc.
  - 4 WAIT_MOC: see the MOC wait rules below.
  - 5 JUMP: state <= cr_addr.
  - 6 CALL: ret_reg <= inc; state <= cr_addr. Single-level only; a second CALL overwrites ret_reg.
  - 7 RET: state <= ret_reg. ret_reg is unchanged.
- MOC wait (n_sel=4):
  - moc=1: state <= inc, wait_cnt <= 0, moc_wait <= 0.
  - moc=0 and wait_cnt < MOC_TIMEOUT-1: state holds, wait_cnt <= wait_cnt+1, moc_wait <= 1.
  - moc=0 and wait_cnt == MOC_TIMEOUT-1: state <= ABORT_ADDR, bus_err <= 1 for exactly one cycle, wait_cnt <= 0, moc_wait <= 0.
  - moc arriving in the same cycle as the timeout compare wins: no abort.
- Any n_sel other than 4 clears wait_cnt and moc_wait.
- bus_err is low in every cycle except the abort pulse.
- ret_reg changes only on CALL or reset.
- Inputs are assumed stable at the edge. No X-propagation handling is required beyond the reset values.
- Expected RTL size: about 150 lines (a next-address case, wait counter, return register, output registers).

Test Plan:
- Reset: assert reset with n_sel=5, cr_addr=0x40 -> state=0x00, moc_wait=0, bus_err=0. Release with n_sel=2 -> state 0x01, 0x02, 0x03 on consecutive edges.
- Conditional branch:
  - state=0x10, n_sel=3, cr_addr=0x30, cond=1, inv=0 -> 0x30.
  - Same with inv=1 -> 0x11.
  - cond=0, inv=1 -> 0x30.
- CALL/RET and wrap:
  - state=0x20, n_sel=6, cr_addr=0x80 -> 0x80.
  - Two INCs -> 0x82; n_sel=7 -> 0x21.
  - state=0xFF, n_sel=2 -> 0x00.
- MOC handshake: state=0x05, n_sel=4, moc low for 3 cycles then high -> state holds at 0x05 with moc_wait=1 for 3 cycles, then 0x06 with moc_wait=0 and no bus_err.
- Timeout: MOC_TIMEOUT=15, n_sel=4, moc held low -> state holds 14 cycles. On the 15th edge state=0xFF and bus_err=1 for one cycle only. Repeat with moc=1 on exactly the 15th cycle -> state=inc, no bus_err.
- Reset mid-wait: 5 cycles into a MOC wait, assert reset -> state=0x00, moc_wait=0, bus_err never pulses. A later wait restarts its count from 0 (a full 15 cycles to timeout).
